// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer around a combinational MIPS-subset ALU: screens one instruction
// at a time, drives the ALU, writes back into regA/regB and returns result/flags/error.
//
// state | meaning
// IDLE  | accept an instruction or a direct register load
// EXEC  | screened instruction on the ALU, result and flags captured at cycle end
// WB    | writeback into regA/regB, response fields loaded
// RESP  | response held until the consumer takes it
module alu_seq_ctrl #(
  parameter logic [31:0] RESET_A = 32'h0000_0000,
  parameter logic [31:0] RESET_B = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic        load_en,
  input  logic        load_sel,
  input  logic [31:0] load_data,
  output logic [31:0] alu_instr,
  output logic [31:0] alu_rega,
  output logic [31:0] alu_regb,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic [2:0]  out_flags,
  output logic [1:0]  out_err,
  output logic [31:0] reg_a,
  output logic [31:0] reg_b
);

  localparam logic [31:0] NOP = 32'h0000_0021;

  typedef enum logic [1:0] {IDLE, EXEC, WB, RESP} state_t;
  typedef enum logic [2:0] {C_ALU, C_ALU_OVF, C_SLT, C_BR, C_MEM} cls_t;

  state_t      state_q, state_d;
  cls_t        cls_q, cls_d;
  logic [1:0]  err_q, err_d;
  logic        dst_q, dst_d;
  logic [31:0] rega_q, rega_d;
  logic [31:0] regb_q, regb_d;
  logic [31:0] res_q, res_d;
  logic [2:0]  flg_q, flg_d;
  logic [31:0] alu_instr_q, alu_instr_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_result_q, out_result_d;
  logic [2:0]  out_flags_q, out_flags_d;
  logic [1:0]  out_err_q, out_err_d;

  // Decode of the incoming word; results are latched at accept time.
  logic [5:0]  dec_op, dec_fn;
  logic        rs_ok, rt_ok, rd_ok, dec_legal, dec_addr_ok, dec_dst;
  cls_t        dec_cls;
  logic [1:0]  dec_err;
  logic [31:0] wb_val;
  logic        wb_en;

  always_comb begin
    dec_op      = in_instr[31:26];
    dec_fn      = in_instr[5:0];
    rs_ok       = (in_instr[25:22] == 4'd0);
    rt_ok       = (in_instr[20:17] == 4'd0);
    rd_ok       = (in_instr[15:12] == 4'd0);
    dec_legal   = 1'b1;
    dec_addr_ok = rs_ok & rt_ok;
    dec_dst     = in_instr[16];
    dec_cls     = C_ALU;
    if (dec_op == 6'h00) begin
      dec_dst     = in_instr[11];
      dec_addr_ok = rs_ok & rt_ok & rd_ok;
      case (dec_fn)
        6'h20, 6'h22:                             dec_cls = C_ALU_OVF;
        6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27: dec_cls = C_ALU;
        6'h2A, 6'h2B:                             dec_cls = C_SLT;
        default:                                  dec_legal = 1'b0;
      endcase
    end else begin
      case (dec_op)
        6'h08:                      dec_cls = C_ALU_OVF;
        6'h09, 6'h0C, 6'h0D, 6'h0E: dec_cls = C_ALU;
        6'h0A, 6'h0B:               dec_cls = C_SLT;
        6'h04, 6'h05:               dec_cls = C_BR;
        6'h23, 6'h2B: begin
          dec_cls     = C_MEM;
          dec_addr_ok = rs_ok;
        end
        default:                    dec_legal = 1'b0;
      endcase
    end
    if (!dec_legal)        dec_err = 2'd1;
    else if (!dec_addr_ok) dec_err = 2'd2;
    else                   dec_err = 2'd0;
  end

  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    err_d        = err_q;
    dst_d        = dst_q;
    rega_d       = rega_q;
    regb_d       = regb_q;
    res_d        = res_q;
    flg_d        = flg_q;
    alu_instr_d  = NOP;
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_flags_d  = out_flags_q;
    out_err_d    = out_err_q;
    wb_val       = res_q;
    wb_en        = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_en) begin
          if (load_sel) regb_d = load_data;
          else          rega_d = load_data;
        end else if (in_valid) begin
          state_d     = EXEC;
          cls_d       = dec_cls;
          err_d       = dec_err;
          dst_d       = dec_dst;
          alu_instr_d = (dec_err == 2'd0) ? in_instr : NOP;
        end
      end
      EXEC: begin
        res_d   = alu_result;
        flg_d   = alu_flags;
        state_d = WB;
      end
      WB: begin
        out_result_d = 32'd0;
        out_flags_d  = 3'd0;
        out_err_d    = err_q;
        if (err_q == 2'd0) begin
          out_flags_d = flg_q;
          case (cls_q)
            C_ALU_OVF: begin
              out_result_d = res_q;
              if (flg_q[2]) out_err_d = 2'd3;
              else          wb_en     = 1'b1;
            end
            C_ALU: begin
              out_result_d = res_q;
              wb_en        = 1'b1;
            end
            C_SLT: begin
              wb_val       = {31'd0, flg_q[1]};
              out_result_d = wb_val;
              wb_en        = 1'b1;
            end
            C_MEM:   out_result_d = res_q;
            default: out_result_d = 32'd0;
          endcase
        end
        if (wb_en) begin
          if (dst_q) regb_d = wb_val;
          else       rega_d = wb_val;
        end
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cls_q        <= C_ALU;
      err_q        <= 2'd0;
      dst_q        <= 1'b0;
      rega_q       <= RESET_A;
      regb_q       <= RESET_B;
      res_q        <= 32'd0;
      flg_q        <= 3'd0;
      alu_instr_q  <= NOP;
      out_valid_q  <= 1'b0;
      out_result_q <= 32'd0;
      out_flags_q  <= 3'd0;
      out_err_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      err_q        <= err_d;
      dst_q        <= dst_d;
      rega_q       <= rega_d;
      regb_q       <= regb_d;
      res_q        <= res_d;
      flg_q        <= flg_d;
      alu_instr_q  <= alu_instr_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_flags_q  <= out_flags_d;
      out_err_q    <= out_err_d;
    end
  end

  // Ready is held low while reset is asserted even though the state already reads IDLE.
  assign in_ready   = rst_n & (state_q == IDLE) & ~load_en;
  assign alu_instr  = alu_instr_q;
  assign alu_rega   = rega_q;
  assign alu_regb   = regb_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign out_flags  = out_flags_q;
  assign out_err    = out_err_q;
  assign reg_a      = rega_q;
  assign reg_b      = regb_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl; the bench plays the ALU with hand-picked result/flag values.
module tb_alu_seq_ctrl;

  localparam logic [31:0] RA  = 32'h1111_1111;
  localparam logic [31:0] RB  = 32'h2222_2222;
  localparam logic [31:0] NOP = 32'h0000_0021;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, load_en, load_sel, out_valid, out_ready;
  logic [31:0] in_instr, load_data, alu_instr, alu_rega, alu_regb, alu_result;
  logic [31:0] out_result, reg_a, reg_b;
  logic [2:0]  alu_flags, out_flags;
  logic [1:0]  out_err;

  int vecs = 0;
  int errs = 0;

  alu_seq_ctrl #(.RESET_A(RA), .RESET_B(RB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .load_en(load_en), .load_sel(load_sel), .load_data(load_data), .alu_instr(alu_instr),
    .alu_rega(alu_rega), .alu_regb(alu_regb), .alu_result(alu_result), .alu_flags(alu_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_flags(out_flags),
    .out_err(out_err), .reg_a(reg_a), .reg_b(reg_b)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic sel, input logic [31:0] d);
    load_en = 1'b1; load_sel = sel; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  // Offers one instruction and walks it to RESP, checking the ALU view and the latency.
  task automatic issue(input logic [31:0] instr, input logic [31:0] res,
                       input logic [2:0] flg, input logic [31:0] exp_ai);
    int n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    vecs++; if (in_ready !== 1'b1) begin $display("FAIL accept_wait in_ready=%b want 1", in_ready); errs++; end
    alu_result = res; alu_flags = flg; in_valid = 1'b1; in_instr = instr;
    tick();
    in_valid = 1'b0;
    vecs++; if (alu_instr !== exp_ai) begin $display("FAIL exec_alu_instr got %h want %h", alu_instr, exp_ai); errs++; end
    tick();
    vecs++; if (out_valid !== 1'b0) begin $display("FAIL wb_out_valid got %b want 0", out_valid); errs++; end
    tick();
    vecs++; if (out_valid !== 1'b1) begin $display("FAIL latency_out_valid got %b want 1", out_valid); errs++; end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    vecs++; if (out_valid !== 1'b0) begin $display("FAIL drain_out_valid got %b want 0", out_valid); errs++; end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vecs++; if (in_ready !== 1'b0)   begin $display("FAIL rst_in_ready got %b want 0", in_ready); errs++; end
    vecs++; if (out_valid !== 1'b0)  begin $display("FAIL rst_out_valid got %b want 0", out_valid); errs++; end
    vecs++; if (out_result !== 0)    begin $display("FAIL rst_out_result got %h want 0", out_result); errs++; end
    vecs++; if (out_flags !== 3'd0)  begin $display("FAIL rst_out_flags got %b want 000", out_flags); errs++; end
    vecs++; if (out_err !== 2'd0)    begin $display("FAIL rst_out_err got %0d want 0", out_err); errs++; end
    vecs++; if (alu_instr !== NOP)   begin $display("FAIL rst_alu_instr got %h want %h", alu_instr, NOP); errs++; end
    vecs++; if (reg_a !== RA)        begin $display("FAIL rst_reg_a got %h want %h", reg_a, RA); errs++; end
    vecs++; if (reg_b !== RB)        begin $display("FAIL rst_reg_b got %h want %h", reg_b, RB); errs++; end
    rst_n = 1'b1;
    tick();
    vecs++; if (in_ready !== 1'b1)   begin $display("FAIL idle_in_ready got %b want 1", in_ready); errs++; end
  endtask

  task automatic test_add();
    do_load(1'b0, 32'd5);
    do_load(1'b1, 32'd7);
    vecs++; if (alu_rega !== 32'd5 || alu_regb !== 32'd7) begin
      $display("FAIL alu_operands got %h/%h want 5/7", alu_rega, alu_regb); errs++; end
    issue(32'h0001_0020, 32'd12, 3'b000, 32'h0001_0020);
    vecs++; if (out_result !== 32'd12) begin $display("FAIL add_result got %h want c", out_result); errs++; end
    vecs++; if (out_err !== 2'd0)      begin $display("FAIL add_err got %0d want 0", out_err); errs++; end
    vecs++; if (reg_a !== 32'd12)      begin $display("FAIL add_reg_a got %h want c", reg_a); errs++; end
    vecs++; if (reg_b !== 32'd7)       begin $display("FAIL add_reg_b got %h want 7", reg_b); errs++; end
    drain();
  endtask

  task automatic test_overflow();
    do_load(1'b0, 32'h7FFF_FFFF);
    do_load(1'b1, 32'd1);
    issue(32'h0001_0820, 32'h8000_0000, 3'b100, 32'h0001_0820);
    vecs++; if (out_err !== 2'd3)            begin $display("FAIL ovf_err got %0d want 3", out_err); errs++; end
    vecs++; if (out_flags !== 3'b100)        begin $display("FAIL ovf_flags got %b want 100", out_flags); errs++; end
    vecs++; if (out_result !== 32'h8000_0000) begin $display("FAIL ovf_result got %h want 80000000", out_result); errs++; end
    vecs++; if (reg_b !== 32'd1)             begin $display("FAIL ovf_reg_b got %h want 1", reg_b); errs++; end
    vecs++; if (reg_a !== 32'h7FFF_FFFF)     begin $display("FAIL ovf_reg_a got %h want 7fffffff", reg_a); errs++; end
    drain();
  endtask

  task automatic test_branch();
    do_load(1'b0, 32'd3);
    do_load(1'b1, 32'd3);
    issue(32'h1001_0000, 32'hDEAD_BEEF, 3'b001, 32'h1001_0000);
    vecs++; if (out_flags !== 3'b001) begin $display("FAIL beq_flags got %b want 001", out_flags); errs++; end
    vecs++; if (out_err !== 2'd0)     begin $display("FAIL beq_err got %0d want 0", out_err); errs++; end
    vecs++; if (out_result !== 0)     begin $display("FAIL beq_result got %h want 0", out_result); errs++; end
    vecs++; if (reg_a !== 32'd3 || reg_b !== 32'd3) begin
      $display("FAIL beq_regs got %h/%h want 3/3", reg_a, reg_b); errs++; end
    drain();
    issue(32'h1401_0000, 32'h0000_0000, 3'b000, 32'h1401_0000);
    vecs++; if (out_flags[0] !== 1'b0) begin $display("FAIL bne_taken got %b want 0", out_flags[0]); errs++; end
    drain();
  endtask

  task automatic test_slt_and_illegal();
    do_load(1'b0, 32'hFFFF_FFFE);
    do_load(1'b1, 32'h0000_0040);
    issue(32'h2801_FFFF, 32'hFFFF_FFFF, 3'b010, 32'h2801_FFFF);
    vecs++; if (reg_b !== 32'd1)      begin $display("FAIL slti_reg_b got %h want 1", reg_b); errs++; end
    vecs++; if (out_result !== 32'd1) begin $display("FAIL slti_result got %h want 1", out_result); errs++; end
    vecs++; if (reg_a !== 32'hFFFF_FFFE) begin $display("FAIL slti_reg_a got %h want fffffffe", reg_a); errs++; end
    drain();
    issue(32'h0000_0000, 32'd5, 3'b001, NOP);
    vecs++; if (out_err !== 2'd1)     begin $display("FAIL sll_err got %0d want 1", out_err); errs++; end
    vecs++; if (out_result !== 0)     begin $display("FAIL sll_result got %h want 0", out_result); errs++; end
    vecs++; if (out_flags !== 3'd0)   begin $display("FAIL sll_flags got %b want 000", out_flags); errs++; end
    vecs++; if (reg_a !== 32'hFFFF_FFFE || reg_b !== 32'd1) begin
      $display("FAIL sll_regs got %h/%h want fffffffe/1", reg_a, reg_b); errs++; end
    drain();
  endtask

  task automatic test_addr_check();
    issue(32'h0001_1020, 32'd9, 3'b000, NOP);
    vecs++; if (out_err !== 2'd2)  begin $display("FAIL rd2_err got %0d want 2", out_err); errs++; end
    vecs++; if (out_result !== 0)  begin $display("FAIL rd2_result got %h want 0", out_result); errs++; end
    vecs++; if (reg_a !== 32'hFFFF_FFFE || reg_b !== 32'd1) begin
      $display("FAIL rd2_regs got %h/%h want fffffffe/1", reg_a, reg_b); errs++; end
    drain();
    // lw does not check rt, so rt=5 is accepted and only the address comes back
    issue(32'h8C05_0004, 32'h0000_0009, 3'b000, 32'h8C05_0004);
    vecs++; if (out_err !== 2'd0)         begin $display("FAIL lw_err got %0d want 0", out_err); errs++; end
    vecs++; if (out_result !== 32'd9)     begin $display("FAIL lw_result got %h want 9", out_result); errs++; end
    vecs++; if (reg_a !== 32'hFFFF_FFFE || reg_b !== 32'd1) begin
      $display("FAIL lw_regs got %h/%h want fffffffe/1", reg_a, reg_b); errs++; end
    drain();
  endtask

  task automatic test_resp_hold();
    issue(32'h3020_00F0, 32'h0000_0030, 3'b000, 32'h3020_00F0);
    vecs++; if (reg_a !== 32'h30) begin $display("FAIL andi_reg_a got %h want 30", reg_a); errs++; end
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin load_en = 1'b1; load_sel = 1'b1; load_data = 32'hBAD0_0000; end
      tick();
      load_en = 1'b0;
      vecs++; if (out_valid !== 1'b1 || out_result !== 32'h30 || out_err !== 2'd0) begin
        $display("FAIL hold_stable cyc%0d got v=%b r=%h e=%0d want 1/30/0", c, out_valid, out_result, out_err); errs++; end
      vecs++; if (in_ready !== 1'b0) begin $display("FAIL hold_in_ready cyc%0d got %b want 0", c, in_ready); errs++; end
    end
    vecs++; if (reg_b !== 32'd1) begin $display("FAIL hold_load_ignored got %h want 1", reg_b); errs++; end
    drain();
    vecs++; if (in_ready !== 1'b1) begin $display("FAIL back_to_idle in_ready got %b want 1", in_ready); errs++; end
  endtask

  task automatic test_load_priority();
    in_valid = 1'b1; in_instr = 32'h0001_0020;
    load_en = 1'b1; load_sel = 1'b0; load_data = 32'h0000_AAAA;
    #1;
    vecs++; if (in_ready !== 1'b0) begin $display("FAIL prio_in_ready got %b want 0", in_ready); errs++; end
    tick();
    in_valid = 1'b0; load_en = 1'b0;
    vecs++; if (reg_a !== 32'h0000_AAAA) begin $display("FAIL prio_reg_a got %h want aaaa", reg_a); errs++; end
    tick(); tick(); tick();
    vecs++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL prio_not_accepted got v=%b rdy=%b want 0/1", out_valid, in_ready); errs++; end
  endtask

  task automatic test_reset_in_exec();
    do_load(1'b0, 32'd5);
    do_load(1'b1, 32'd7);
    alu_result = 32'd12; alu_flags = 3'b000;
    in_valid = 1'b1; in_instr = 32'h0001_0020;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    vecs++; if (reg_a !== RA || reg_b !== RB) begin
      $display("FAIL exec_rst_regs got %h/%h want %h/%h", reg_a, reg_b, RA, RB); errs++; end
    vecs++; if (out_valid !== 1'b0) begin $display("FAIL exec_rst_out_valid got %b want 0", out_valid); errs++; end
    rst_n = 1'b1;
    tick(); tick(); tick();
    vecs++; if (out_valid !== 1'b0 || reg_a !== RA) begin
      $display("FAIL exec_rst_no_wb got v=%b a=%h want 0/%h", out_valid, reg_a, RA); errs++; end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'd0; load_en = 1'b0; load_sel = 1'b0;
    load_data = 32'd0; alu_result = 32'd0; alu_flags = 3'd0; out_ready = 1'b0;
    test_reset();
    test_add();
    test_overflow();
    test_branch();
    test_slt_and_illegal();
    test_addr_check();
    test_resp_hold();
    test_load_priority();
    test_reset_in_exec();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
- Multi-cycle sequencer around the combinational MIPS-subset ALU.
- Owns the 2-entry register file: address 0 = regA, address 1 = regB.
- Accepts one instruction at a time over a valid/ready handshake and screens it before the ALU sees it.
- Drives the ALU, writes results back into regA/regB, and returns result, flags and an error code over a second valid/ready handshake.

Parameters:
- RESET_A, 32'h0000_0000, reset value of regA
- RESET_B, 32'h0000_0000, reset value of regB

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  reset, synchronous and active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  controller can accept an instruction
- in_instr  in  32  MIPS instruction word
- load_en  in  1  direct register load request
- load_sel  in  1  load target: 0 = regA, 1 = regB
- load_data  in  32  value to load
- alu_instr  out  32  instruction presented to the ALU
- alu_rega  out  32  regA value to the ALU
- alu_regb  out  32  regB value to the ALU
- alu_result  in  32  ALU result
- alu_flags  in  3  ALU flags: [0] zero/branch, [1] less-than, [2] overflow
- out_valid  out  1  response valid
- out_ready  in  1  consumer accepts the response
- out_result  out  32  value written back, or computed address for lw/sw
- out_flags  out  3  captured ALU flags
- out_err  out  2  0 = ok, 1 = unsupported opcode/funct, 2 = bad register address, 3 = overflow (write suppressed)
- reg_a  out  32  current regA
- reg_b  out  32  current regB

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE, regA = RESET_A, regB = RESET_B.
  - in_ready = 0, out_valid = 0, out_result = 0, out_flags = 0, out_err = 0.
  - alu_instr = 32'h0000_0021 (NOP).
  - Reset mid-operation aborts the instruction; no writeback occurs.
- States and transitions:
  - IDLE: in_ready = 1 unless load_en = 1.
    - load_en = 1: write load_data to the selected register; stay in IDLE. Load has priority over in_valid.
    - Else in_valid & in_ready: latch in_instr and go to EXEC.
    - load_en outside IDLE is ignored.
  - EXEC (1 cycle): decode the latched instruction.
    - Legal and register addresses OK: alu_instr = latched instruction.
    - Otherwise: alu_instr = NOP, so the ALU never sees an unrecognized word.
    - alu_rega/alu_regb always mirror regA/regB.
    - At the end of the cycle, capture alu_result and alu_flags; go to WB.
  - WB (1 cycle): perform writeback per the rules below; load out_result/out_flags/out_err; go to RESP.
  - RESP: out_valid = 1 and outputs held stable until out_ready = 1, then go to IDLE.
    - in_ready = 0 while in RESP.
    - out_valid & out_ready in the same cycle: IDLE next cycle.
- Latency:
  - Accept at edge T; registers updated and out_valid high after edge T+2.
  - Minimum throughput: 1 instruction per 4 cycles with out_ready held high.
- Legal set:
  - R-type, op = 0, funct in {20,21,22,23,24,25,26,27,2A,2B} hex.
  - I-type, op in {08,09,0C,0D,0E,0A,0B,04,05,23,2B} hex.
  - Shifts and everything else: err = 1, no writeback, out_flags = 0, out_result = 0.
- Register address check:
  - rs, and rt for R-type/beq/bne, must be 0 or 1.
  - Destination must be 0 or 1: rd = instr[15:11] for R-type, rt for I-type ALU ops.
  - Violation: err = 2, no writeback, out_result = 0. Illegal opcode (err 1) takes precedence.
- Writeback:
  - add/addu/sub/subu/and/or/xor/nor/addi/addiu/andi/ori/xori: dest = alu_result.
  - slt/sltu/slti/sltiu: dest = {31'b0, alu_flags[1]}; out_result is the same value.
  - add/addi/sub with alu_flags[2] = 1: write suppressed, err = 3, out_result = alu_result.
  - beq/bne: no write; out_result = 0; out_flags[0] is the branch decision.
  - lw/sw: no write; out_result = alu_result (effective address).
  - dest = regA and dest = regB are exclusive; the non-destination register is unchanged.
- Width: all arithmetic is performed in the ALU; the controller does no arithmetic beyond decode compares.

Test Plan:
- regA = 5, regB = 7; add rd=0, rs=0, rt=1 (32'h0001_0020) -> out_result = 12, regA = 12, err 0, out_valid 2 cycles after accept.
- regA = 7FFF_FFFF, regB = 1; add rd=1 -> flags[2] = 1, err 3, regB stays 1, out_result = 8000_0000.
- regA = 3, regB = 3; beq rs=0, rt=1 (32'h1001_0000) -> out_flags = 3'b001, err 0, regs unchanged. Then bne -> out_flags[0] = 0.
- slti rt=1, rs=0, imm = FFFF with regA = FFFF_FFFE -> regB = 1. Then sll (32'h0000_0000) -> err 1, alu_instr = 0000_0021 during EXEC.
- out_ready held low 5 cycles in RESP -> out_* stable, in_ready = 0, a load_en pulse is ignored. Then out_ready = 1 -> IDLE next cycle.
- load_en and in_valid together in IDLE -> load wins, in_ready = 0. rst_n low during EXEC -> regs return to RESET_A/RESET_B, out_valid = 0, no writeback.
